md_unit: RTL and testbench



---
 rtl/md_unit_pkg.sv | 26 ++
 rtl/md_calc.sv | 56 +++++
 rtl/md_unit.sv | 111 +++++++++++
 tb/tb_md_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Multiply/divide unit shared types.
// Op encodings are shared with the controller.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result for latched mult/div operands.
// A zero divisor passes the current HI/LO through.
module md_calc
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output md_res_t     res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_m;
  logic [31:0] r_m;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a})
           * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    // Signed divide on magnitudes; MIN/-1 wraps back to MIN.
    mag_a  = a[31] ? -a : a;
    mag_b  = b[31] ? -b : b;
    b_zero = (b == 32'd0);
    q_m    = b_zero ? 32'd0 : mag_a / mag_b;
    r_m    = b_zero ? 32'd0 : mag_a % mag_b;
    q_u    = b_zero ? 32'd0 : a / b;
    r_u    = b_zero ? 32'd0 : a % b;
    res    = '{hi: hi, lo: lo};
    unique case (op)
      MD_MULT:  res = md_res_t'(prod_s);
      MD_MULTU: res = md_res_t'(prod_u);
      MD_DIV: begin
        if (!b_zero) begin
          res.lo = (a[31] ^ b[31]) ? -q_m : q_m;
          res.hi = a[31] ? -r_m : r_m;
        end
      end
      MD_DIVU: begin
        if (!b_zero) begin
          res.lo = q_u;
          res.hi = r_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Operands latch at start; result commits when the countdown expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        readHi,
  output logic        busy,
  output logic [31:0] mdOut
);

  localparam int MAX_CYC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  md_state_e   state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  md_op_e      op_in, op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi, lo;
  logic        latch, commit;
  logic        wr_hi, wr_lo;
  md_res_t     res;

  assign op_in = md_op_e'(op);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          unique case (op_in)
            MD_MULT, MD_MULTU: begin
              latch   = 1'b1;
              cnt_n   = CNT_W'(MULT_CYCLES);
              state_n = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              latch   = 1'b1;
              cnt_n   = CNT_W'(DIV_CYCLES);
              state_n = ST_BUSY;
            end
            MD_MTHI: wr_hi = 1'b1;
            MD_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        op_q <= op_in;
        a_q  <= A;
        b_q  <= B;
      end
      if (commit) begin
        hi <= res.hi;
        lo <= res.lo;
      end
      if (wr_hi) hi <= A;
      if (wr_lo) lo <= A;
    end
  end

  md_calc u_calc (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .hi  (hi),
    .lo  (lo),
    .res (res)
  );

  assign busy  = (state == ST_BUSY);
  assign mdOut = readHi ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit.
// Reference model uses 64-bit integer arithmetic on the operands.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        readHi;
  logic        busy;
  logic [31:0] mdOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .readHi (readHi),
    .busy   (busy),
    .mdOut  (mdOut)
  );

  function automatic logic [63:0] ref_md(
    input int o, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (o)
      1: return 64'(sa * sb);
      2: return {32'd0, a} * {32'd0, b};
      3: begin
        if (b == 0) return {hi, lo};
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {r[31:0], q[31:0]};
      end
      4: begin
        if (b == 0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic read_md(output logic [31:0] h, output logic [31:0] l);
    readHi = 1'b1;
    #1 h = mdOut;
    readHi = 1'b0;
    #1 l = mdOut;
  endtask

  // Issue a mult/div and follow it through every busy cycle.
  task automatic run_op(input int o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject,
                        input string tag);
    logic [63:0] exp;
    logic [31:0] h, l;
    int n;
    n   = (o == 1 || o == 2) ? MC : DC;
    exp = ref_md(o, a, b, m_hi, m_lo);
    @(negedge clk);
    start = 1'b1; op = 3'(o); A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    for (int i = 1; i <= n; i++) begin
      A = $urandom;
      B = $urandom;
      if (inject && i == 3) begin
        start = 1'b1; op = 3'd5; A = 32'h0000ABCD;
      end else begin
        start = 1'b0;
      end
      read_md(h, l);
      checks++;
      if (busy !== 1'b1 || h !== m_hi || l !== m_lo) begin
        errors++;
        $display("FAIL %s busy_cycle%0d: busy=%b hi=%h lo=%h, expected busy=1 hi=%h lo=%h",
                 tag, i, busy, h, l, m_hi, m_lo);
      end
      @(negedge clk);
    end
    start = 1'b0;
    read_md(h, l);
    checks++;
    if (busy !== 1'b0 || h !== exp[63:32] || l !== exp[31:0]) begin
      errors++;
      $display("FAIL %s result: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h",
               tag, busy, h, l, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic run_mt(input int o, input logic [31:0] a,
                        input string tag);
    logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; op = 3'(o); A = a;
    read_md(h, l);
    checks++;
    if (h !== m_hi || l !== m_lo) begin
      errors++;
      $display("FAIL %s before_edge: hi=%h lo=%h, expected hi=%h lo=%h",
               tag, h, l, m_hi, m_lo);
    end
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    if (o == 5) m_hi = a;
    else        m_lo = a;
    read_md(h, l);
    checks++;
    if (busy !== 1'b0 || h !== m_hi || l !== m_lo) begin
      errors++;
      $display("FAIL %s: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h",
               tag, busy, h, l, m_hi, m_lo);
    end
  endtask

  task automatic run_nop(input int o, input string tag);
    logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; op = 3'(o); A = $urandom; B = $urandom;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    read_md(h, l);
    checks++;
    if (busy !== 1'b0 || h !== m_hi || l !== m_lo) begin
      errors++;
      $display("FAIL %s: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h",
               tag, busy, h, l, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b0; op = 3'd0;
    A = 32'd0; B = 32'd0; readHi = 1'b0;
    repeat (3) @(negedge clk);
    read_md(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b hi=%h lo=%h, expected 0 0 0",
               busy, h, l);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult;
    run_op(1, 32'hFFFFFFFF, 32'd2, 1'b0, "mult_neg1x2");
    run_op(2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu_max_x2");
    run_op(1, 32'h80000000, 32'h80000000, 1'b0, "mult_min_sq");
    for (int i = 0; i < 4; i++) begin
      run_op(1, $urandom, $urandom, 1'b0, "mult_rand");
      run_op(2, $urandom, $urandom, 1'b0, "multu_rand");
    end
  endtask

  task automatic test_div;
    run_op(3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg7_by2");
    run_op(3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
    run_op(3, 32'd7, 32'hFFFFFFFE, 1'b0, "div_7_by_neg2");
    run_op(4, 32'hFFFFFFFF, 32'd10, 1'b0, "divu_max_by10");
    for (int i = 0; i < 4; i++) begin
      run_op(3, $urandom, $urandom_range(1, 1000) * (i[0] ? -1 : 1),
             1'b0, "div_rand");
      run_op(4, $urandom, $urandom_range(1, 70000), 1'b0, "divu_rand");
    end
  endtask

  task automatic test_div_zero;
    run_mt(5, 32'h11, "mthi_preload");
    run_mt(6, 32'h22, "mtlo_preload");
    run_op(4, 32'd7, 32'd0, 1'b0, "divu_by_zero");
    run_op(3, 32'hDEADBEEF, 32'd0, 1'b0, "div_by_zero");
  endtask

  task automatic test_busy_ignore;
    run_op(3, 32'd1000, 32'd7, 1'b1, "div_mthi_ignored");
    run_op(1, 32'h12345678, 32'h9ABCDEF0, 1'b1, "mult_mthi_ignored");
  endtask

  task automatic test_nop;
    run_nop(0, "op_none");
    run_nop(7, "op_reserved");
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] h, l;
    run_mt(5, 32'h1234, "mthi_pre_reset");
    run_mt(6, 32'h5678, "mtlo_pre_reset");
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = $urandom; B = $urandom;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    #1 reset = 1'b1;
    read_md(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h, expected 0 0 0",
               busy, h, l);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (MC) @(negedge clk);
    read_md(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b hi=%h lo=%h, expected 0 0 0",
               busy, h, l);
    end
    run_mt(6, 32'h5, "mtlo_after_reset");
    run_op(2, 32'h10000, 32'h10000, 1'b0, "multu_after_reset");
  endtask

  task automatic test_back_to_back;
    int o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = $urandom_range(0, 7);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      case (o)
        1, 2, 3, 4: run_op(o, a, b, 1'b0, "b2b_muldiv");
        5, 6:       run_mt(o, a, "b2b_mt");
        default:    run_nop(o, "b2b_nop");
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_busy_ignore;
    test_nop;
    test_reset_mid_busy;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
